// File: rtl/mtr_pkg.sv
// Shared types and constants for the motor command sequencer.
// Speeds are 11-bit signed, kept inside a symmetric +/-1023 range.
package mtr_pkg;

    localparam int SPD_W = 11;

    localparam logic signed [SPD_W-1:0] SPD_MAX = 11'sd1023;
    localparam logic signed [SPD_W-1:0] SPD_MIN = -11'sd1023;

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        HOLD,
        RAMP_DN
    } mtr_state_t;

    // Only -1024 can fall outside the symmetric range; clamp it to -1023.
    function automatic logic signed [SPD_W-1:0] sat_spd(input logic signed [SPD_W-1:0] v);
        logic signed [SPD_W-1:0] r;
        r = v;
        if (v < SPD_MIN) begin
            r = SPD_MIN;
        end else if (v > SPD_MAX) begin
            r = SPD_MAX;
        end
        return r;
    endfunction

endpackage

// File: rtl/mtr_seq_slew.sv
// Per-wheel slew limiter: next speed moves toward the target by at most STEP,
// landing exactly on the target without overshoot.
module spd_slew
    import mtr_pkg::*;
#(
    parameter int unsigned STEP = 16
) (
    input  logic signed [SPD_W-1:0] cur,
    input  logic signed [SPD_W-1:0] tgt,
    output logic signed [SPD_W-1:0] nxt,
    output logic                    at_tgt
);

    localparam int EW = SPD_W + 1;
    localparam logic signed [EW-1:0] STEP_E = EW'(STEP);

    logic signed [EW-1:0] cur_e;
    logic signed [EW-1:0] tgt_e;
    logic signed [EW-1:0] diff;
    logic signed [EW-1:0] mag;
    logic signed [EW-1:0] moved;

    // One extra bit keeps target-minus-current from wrapping.
    always_comb begin
        cur_e = {cur[SPD_W-1], cur};
        tgt_e = {tgt[SPD_W-1], tgt};
        diff  = tgt_e - cur_e;
        mag   = diff[EW-1] ? -diff : diff;
        moved = diff[EW-1] ? (cur_e - STEP_E) : (cur_e + STEP_E);
        nxt   = tgt;
        if (mag > STEP_E) begin
            nxt = moved[SPD_W-1:0];
        end
    end

    assign at_tgt = (nxt == tgt);

endmodule

// File: rtl/mtr_seq.sv
// Motor command sequencer: ramps both wheels to their targets, holds for a
// commanded number of ticks, ramps back to zero and pulses done.
module mtr_seq
    import mtr_pkg::*;
#(
    parameter int unsigned STEP     = 16,
    parameter int unsigned TICK_DIV = 1024,
    parameter int unsigned DUR_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_vld,
    output logic                    cmd_rdy,
    input  logic signed [SPD_W-1:0] cmd_lft,
    input  logic signed [SPD_W-1:0] cmd_rght,
    input  logic [DUR_W-1:0]        cmd_dur,
    input  logic                    abort,
    output logic signed [SPD_W-1:0] lft_spd,
    output logic signed [SPD_W-1:0] rght_spd,
    output logic                    busy,
    output logic                    done
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    mtr_state_t              state;
    mtr_state_t              state_nxt;
    logic [CNT_W-1:0]        tick_cnt;
    logic [DUR_W-1:0]        dur_cnt;
    logic [DUR_W-1:0]        dur_lat;
    logic signed [SPD_W-1:0] tgt_lft;
    logic signed [SPD_W-1:0] tgt_rght;
    logic signed [SPD_W-1:0] slew_tgt_lft;
    logic signed [SPD_W-1:0] slew_tgt_rght;
    logic signed [SPD_W-1:0] lft_nxt;
    logic signed [SPD_W-1:0] rght_nxt;
    logic                    lft_at;
    logic                    rght_at;
    logic                    tick;
    logic                    abort_hit;

    assign tick      = (state != IDLE) && (tick_cnt == CNT_LAST);
    assign abort_hit = abort && ((state == RAMP_UP) || (state == HOLD));
    assign cmd_rdy   = (state == IDLE);
    assign busy      = (state != IDLE);

    assign slew_tgt_lft  = (state == RAMP_DN) ? '0 : tgt_lft;
    assign slew_tgt_rght = (state == RAMP_DN) ? '0 : tgt_rght;

    spd_slew #(.STEP(STEP)) u_slew_lft (
        .cur    (lft_spd),
        .tgt    (slew_tgt_lft),
        .nxt    (lft_nxt),
        .at_tgt (lft_at)
    );

    spd_slew #(.STEP(STEP)) u_slew_rght (
        .cur    (rght_spd),
        .tgt    (slew_tgt_rght),
        .nxt    (rght_nxt),
        .at_tgt (rght_at)
    );

    // Abort takes priority over any tick-driven exit from RAMP_UP or HOLD.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_vld) begin
                    state_nxt = RAMP_UP;
                end
            end
            RAMP_UP: begin
                if (abort) begin
                    state_nxt = RAMP_DN;
                end else if (tick && lft_at && rght_at) begin
                    state_nxt = (dur_lat == '0) ? RAMP_DN : HOLD;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_nxt = RAMP_DN;
                end else if (tick && (dur_cnt <= DUR_W'(1))) begin
                    state_nxt = RAMP_DN;
                end
            end
            RAMP_DN: begin
                if (tick && lft_at && rght_at) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            dur_cnt  <= '0;
            dur_lat  <= '0;
            tgt_lft  <= '0;
            tgt_rght <= '0;
            lft_spd  <= '0;
            rght_spd <= '0;
            done     <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == RAMP_DN) && (state_nxt == IDLE);

            if (state == IDLE) begin
                tick_cnt <= '0;
                if (cmd_vld) begin
                    tgt_lft  <= sat_spd(cmd_lft);
                    tgt_rght <= sat_spd(cmd_rght);
                    dur_lat  <= cmd_dur;
                end
            end else begin
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            end

            // An abort freezes the speeds for the cycle it lands in.
            if (tick && !abort_hit) begin
                lft_spd  <= lft_nxt;
                rght_spd <= rght_nxt;
            end

            if ((state == RAMP_UP) && (state_nxt == HOLD)) begin
                dur_cnt <= dur_lat;
            end else if ((state == HOLD) && tick) begin
                dur_cnt <= dur_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mtr_seq.sv
// Directed testbench for mtr_seq with STEP=16, TICK_DIV=4; all expected
// values are hand-computed edge counts after the accepting clock edge.
module tb_mtr_seq;

    logic               clk;
    logic               rst_n;
    logic               cmd_vld;
    logic               cmd_rdy;
    logic signed [10:0] cmd_lft;
    logic signed [10:0] cmd_rght;
    logic [15:0]        cmd_dur;
    logic               abort;
    logic signed [10:0] lft_spd;
    logic signed [10:0] rght_spd;
    logic               busy;
    logic               done;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int max_step = 0;
    int min_lft  = 0;
    int prev_lft = 0;
    logic mon_en = 1'b0;
    int snap;

    mtr_seq #(
        .STEP     (16),
        .TICK_DIV (4),
        .DUR_W    (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_vld  (cmd_vld),
        .cmd_rdy  (cmd_rdy),
        .cmd_lft  (cmd_lft),
        .cmd_rght (cmd_rght),
        .cmd_dur  (cmd_dur),
        .abort    (abort),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts done pulses and tracks the worst left-wheel step while enabled.
    always @(negedge clk) begin
        int d;
        if (done === 1'b1) done_cnt++;
        d = int'(lft_spd) - prev_lft;
        if (d < 0) d = -d;
        if (!mon_en) begin
            max_step = 0;
            min_lft  = 0;
        end else if (rst_n) begin
            if (d > max_step) max_step = d;
            if (int'(lft_spd) < min_lft) min_lft = int'(lft_spd);
        end
        prev_lft = int'(lft_spd);
    end

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int l, input int r, input int d);
        cmd_lft  = 11'(l);
        cmd_rght = 11'(r);
        cmd_dur  = 16'(d);
        cmd_vld  = 1'b1;
        step(1);
        cmd_vld  = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        cmd_vld  = 1'b0;
        cmd_lft  = '0;
        cmd_rght = '0;
        cmd_dur  = '0;
        abort    = 1'b0;
        step(3);
        checkOutput("rst_lft", int'(lft_spd), 0);
        checkOutput("rst_rght", int'(rght_spd), 0);
        checkOutput("rst_rdy", int'(cmd_rdy), 1);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        rst_n = 1'b1;
        step(2);

        // Basic move 64 / -32, hold 2 ticks
        snap = done_cnt;
        applyStimulus(64, -32, 2);
        checkOutput("basic_busy_e0", int'(busy), 1);
        checkOutput("basic_rdy_e0", int'(cmd_rdy), 0);
        step(3);
        checkOutput("basic_lft_e3", int'(lft_spd), 0);
        step(1);
        checkOutput("basic_lft_e4", int'(lft_spd), 16);
        checkOutput("basic_rght_e4", int'(rght_spd), -16);
        step(4);
        checkOutput("basic_lft_e8", int'(lft_spd), 32);
        checkOutput("basic_rght_e8", int'(rght_spd), -32);
        step(4);
        checkOutput("basic_lft_e12", int'(lft_spd), 48);
        checkOutput("basic_rght_e12", int'(rght_spd), -32);
        step(4);
        checkOutput("basic_lft_e16", int'(lft_spd), 64);
        step(8);
        checkOutput("basic_lft_e24", int'(lft_spd), 64);
        checkOutput("basic_rght_e24", int'(rght_spd), -32);
        step(4);
        checkOutput("basic_lft_e28", int'(lft_spd), 48);
        checkOutput("basic_rght_e28", int'(rght_spd), -16);
        step(4);
        checkOutput("basic_rght_e32", int'(rght_spd), 0);
        step(4);
        checkOutput("basic_lft_e36", int'(lft_spd), 16);
        step(3);
        checkOutput("basic_done_e39", int'(done), 0);
        checkOutput("basic_busy_e39", int'(busy), 1);
        step(1);
        checkOutput("basic_done_e40", int'(done), 1);
        checkOutput("basic_busy_e40", int'(busy), 0);
        checkOutput("basic_rdy_e40", int'(cmd_rdy), 1);
        checkOutput("basic_lft_e40", int'(lft_spd), 0);
        step(1);
        checkOutput("basic_done_e41", int'(done), 0);
        checkOutput("basic_done_count", done_cnt - snap, 1);

        // Non-multiple target, zero hold
        applyStimulus(20, 0, 0);
        step(4);
        checkOutput("nm_lft_e4", int'(lft_spd), 16);
        step(4);
        checkOutput("nm_lft_e8", int'(lft_spd), 20);
        step(4);
        checkOutput("nm_lft_e12", int'(lft_spd), 4);
        step(3);
        checkOutput("nm_done_e15", int'(done), 0);
        step(1);
        checkOutput("nm_done_e16", int'(done), 1);
        checkOutput("nm_lft_e16", int'(lft_spd), 0);

        // Zero targets still spend one tick in RAMP_UP
        applyStimulus(0, 0, 0);
        step(7);
        checkOutput("zero_busy_e7", int'(busy), 1);
        checkOutput("zero_done_e7", int'(done), 0);
        step(1);
        checkOutput("zero_done_e8", int'(done), 1);

        // Saturation of -1024
        mon_en = 1'b1;
        applyStimulus(-1024, 0, 1);
        step(252);
        checkOutput("sat_lft_e252", int'(lft_spd), -1008);
        step(4);
        checkOutput("sat_lft_e256", int'(lft_spd), -1023);
        step(4);
        checkOutput("sat_lft_e260", int'(lft_spd), -1023);
        step(252);
        checkOutput("sat_lft_e512", int'(lft_spd), -15);
        step(4);
        checkOutput("sat_done_e516", int'(done), 1);
        checkOutput("sat_lft_e516", int'(lft_spd), 0);
        checkOutput("sat_max_step", max_step, 16);
        checkOutput("sat_min_lft", min_lft, -1023);
        mon_en = 1'b0;
        step(1);

        // Abort in HOLD
        applyStimulus(48, 48, 3);
        step(13);
        abort = 1'b1;
        step(1);
        checkOutput("abh_busy_e14", int'(busy), 1);
        checkOutput("abh_lft_e14", int'(lft_spd), 48);
        step(2);
        checkOutput("abh_lft_e16", int'(lft_spd), 32);
        checkOutput("abh_rght_e16", int'(rght_spd), 32);
        step(4);
        checkOutput("abh_lft_e20", int'(lft_spd), 16);
        abort = 1'b0;
        step(3);
        checkOutput("abh_done_e23", int'(done), 0);
        step(1);
        checkOutput("abh_done_e24", int'(done), 1);
        checkOutput("abh_lft_e24", int'(lft_spd), 0);

        // Abort coinciding with the last HOLD tick
        applyStimulus(48, 48, 2);
        step(19);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        checkOutput("abl_lft_e20", int'(lft_spd), 48);
        step(4);
        checkOutput("abl_lft_e24", int'(lft_spd), 32);
        step(4);
        checkOutput("abl_lft_e28", int'(lft_spd), 16);
        step(4);
        checkOutput("abl_done_e32", int'(done), 1);
        checkOutput("abl_lft_e32", int'(lft_spd), 0);

        // Abort landing on a RAMP_UP tick keeps current speeds
        applyStimulus(48, 48, 2);
        step(7);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        checkOutput("abu_lft_e8", int'(lft_spd), 16);
        step(4);
        checkOutput("abu_lft_e12", int'(lft_spd), 0);
        checkOutput("abu_done_e12", int'(done), 1);

        // Command during RAMP_UP is ignored
        applyStimulus(32, 32, 1);
        step(1);
        cmd_lft  = -11'sd100;
        cmd_rght = -11'sd100;
        cmd_dur  = 16'd5;
        cmd_vld  = 1'b1;
        step(1);
        cmd_vld  = 1'b0;
        checkOutput("rej_rdy_e2", int'(cmd_rdy), 0);
        step(2);
        checkOutput("rej_lft_e4", int'(lft_spd), 16);
        step(4);
        checkOutput("rej_lft_e8", int'(lft_spd), 32);
        checkOutput("rej_rght_e8", int'(rght_spd), 32);
        step(8);
        checkOutput("rej_lft_e16", int'(lft_spd), 16);
        step(4);
        checkOutput("rej_done_e20", int'(done), 1);
        step(12);
        checkOutput("rej_busy_after", int'(busy), 0);
        checkOutput("rej_lft_after", int'(lft_spd), 0);
        checkOutput("rej_rght_after", int'(rght_spd), 0);

        // Reset mid RAMP_UP
        applyStimulus(64, 64, 1);
        step(9);
        checkOutput("rmid_lft_e9", int'(lft_spd), 32);
        snap = done_cnt;
        rst_n = 1'b0;
        #1;
        checkOutput("rmid_lft_async", int'(lft_spd), 0);
        checkOutput("rmid_rght_async", int'(rght_spd), 0);
        checkOutput("rmid_busy_async", int'(busy), 0);
        step(2);
        rst_n = 1'b1;
        step(1);
        checkOutput("rmid_rdy", int'(cmd_rdy), 1);
        checkOutput("rmid_busy", int'(busy), 0);
        step(12);
        checkOutput("rmid_no_done", done_cnt - snap, 0);
        checkOutput("rmid_lft_after", int'(lft_spd), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mtr_seq.md
# mtr_seq

Motor command sequencer that sits directly upstream of the motor driver and owns its `lft_spd`/`rght_spd` inputs. It accepts one move command at a time: signed left and right target speeds plus a hold duration. It ramps both wheels toward their targets in bounded steps, holds for the commanded number of ticks, then ramps both to zero and pulses `done`. An abort input forces an immediate controlled ramp-down, so the driver never sees a speed step larger than `STEP`.

## Interface
Parameters:
- `STEP`, default 16: maximum speed change per wheel per tick (unsigned, 1..1023).
- `TICK_DIV`, default 1024: `clk` cycles per ramp/hold tick (≥2).
- `DUR_W`, default 16: width of the hold-duration field.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous active-low reset.
- `cmd_vld`  in  1  command valid.
- `cmd_rdy`  out  1  high only in IDLE; a command is accepted when `cmd_vld && cmd_rdy`.
- `cmd_lft`  in  11  signed left target speed.
- `cmd_rght`  in  11  signed right target speed.
- `cmd_dur`  in  DUR_W  hold length in ticks.
- `abort`  in  1  level; any non-IDLE state goes to RAMP_DN.
- `lft_spd`  out  11  signed registered speed to the driver.
- `rght_spd`  out  11  signed registered speed to the driver.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse when the sequence returns to IDLE.

## Operation
- States: IDLE, RAMP_UP, HOLD, RAMP_DN.
- IDLE:
  - On accept, latch the targets and `cmd_dur` and clear the tick counter.
  - Targets are saturated at latch time: -1024 becomes -1023, so the range is symmetric ±1023.
  - Next state is RAMP_UP.
- Tick: the counter runs 0..TICK_DIV-1 in non-IDLE states. `tick` is asserted when the count equals TICK_DIV-1; the counter then wraps to 0.
- Slew rule, per wheel, on `tick`:
  - diff = target − current, computed in 12-bit signed.
  - If |diff| ≤ STEP, current = target. Otherwise current moves by ±STEP toward target.
  - The value never overshoots and never wraps.
- RAMP_UP:
  - On the tick where both wheels equal their targets after the update, go to HOLD.
  - If `cmd_dur` == 0, go directly to RAMP_DN instead.
- HOLD:
  - The duration counter loads `cmd_dur` on entry and decrements each tick.
  - On the tick where it reaches 0, go to RAMP_DN.
- RAMP_DN:
  - The targets are forced to 0 and the slew rule is reused.
  - On the tick where both wheels are 0, go to IDLE and pulse `done` in that same cycle.
- Abort:
  - From RAMP_UP or HOLD, go to RAMP_DN on the next clock edge. Current speeds are kept and the tick counter is not cleared.
  - In RAMP_DN, abort has no effect. In IDLE, abort is ignored.
  - A `done` pulse is still generated at completion.
- Abort wins over a HOLD/RAMP_UP exit that falls in the same cycle.
- `cmd_vld` outside IDLE is ignored; the command is not queued.
- A zero target on both wheels still traverses RAMP_UP for 1 tick.

## Timing
- Reset values: state IDLE, `lft_spd`=0, `rght_spd`=0, `cmd_rdy`=1, `busy`=0, `done`=0, all counters 0.
- Accept at edge N: `busy`=1 and `cmd_rdy`=0 from N+1.
- The first speed update is visible TICK_DIV cycles after accept (the output is registered on the tick cycle).
- `done` goes high in the same cycle as `busy` falls and `cmd_rdy` rises. A new command can be accepted in the following cycle.
- Reset mid-operation: the outputs go to 0 immediately (asynchronously). No `done` pulse is generated.

## Structure
- Package `mtr_pkg`:
  - `SPD_W`=11.
  - State enum `mtr_state_t` {IDLE, RAMP_UP, HOLD, RAMP_DN}.
  - Constants `SPD_MAX`=1023 and `SPD_MIN`=-1023.
- Sub-module `spd_slew`, instanced once per wheel:
  - Combinational next-value computation from current, target and STEP.
  - Outputs the next speed and an `at_tgt` flag.
- The top level holds the FSM, tick counter, duration counter and output registers.

## Test plan
All scenarios use STEP=16 and TICK_DIV=4.

- Basic move: `cmd_lft`=64, `cmd_rght`=-32, `cmd_dur`=2.
  - Left steps 16/32/48/64; right steps -16/-32 then holds at -32.
  - HOLD lasts 2 ticks, RAMP_DN lasts 4 ticks.
  - `done` pulses exactly 40 cycles after accept.
- Non-multiple target: `cmd_lft`=20, `cmd_rght`=0, `cmd_dur`=0.
  - Left goes 16 then 20, then ramps down 4 then 0; HOLD is never entered.
- Saturation: `cmd_lft`=11'h400.
  - Left ends at -1023, never -1024; every step magnitude is ≤16.
- Abort: assert `abort` in HOLD with `cmd_lft`=`cmd_rght`=48.
  - Next state is RAMP_DN; speeds go 32/16/0; `done` pulses.
  - Check abort coinciding with the last HOLD tick.
- Busy rejection: pulse `cmd_vld` with new targets during RAMP_UP.
  - Outputs are unaffected and the command is not executed after `done`.
- Reset mid-RAMP_UP:
  - Outputs go to 0 asynchronously; `cmd_rdy`=1 after deassert; no `done` pulse.
